// File: rtl/pulse_to_degrees.sv
// pulse_to_degrees
//   Measures the high time of a servo-style PWM pulse in units of in_Tick
//   strobes and converts it to an angle: degrees = count * P_MUL / P_DIV,
//   truncated. Pulses longer than P_MAX_CYCLES are reported as errors.
//
// Parameters
//   P_MAX_CYCLES  largest legal pulse width in ticks (maps to 360 degrees)
//   P_MUL         numerator of the cycles-to-degrees ratio
//   P_DIV         denominator of the cycles-to-degrees ratio
//
// Ports
//   in_Clk       system clock, rising edge
//   in_Rst       asynchronous active-high reset
//   in_Pulse     asynchronous PWM input
//   in_Tick      one-clock count-enable strobe
//   out_Degrees  last valid measured angle, 0..360
//   out_Valid    one-clock strobe, out_Degrees updated this cycle
//   out_Error    one-clock strobe, pulse exceeded P_MAX_CYCLES
//   out_Busy     high whenever the FSM is not idle
module pulse_to_degrees #(
  parameter int unsigned P_MAX_CYCLES = 200,
  parameter int unsigned P_MUL        = 18,
  parameter int unsigned P_DIV        = 10
) (
  input  logic       in_Clk,
  input  logic       in_Rst,
  input  logic       in_Pulse,
  input  logic       in_Tick,
  output logic [8:0] out_Degrees,
  output logic       out_Valid,
  output logic       out_Error,
  output logic       out_Busy
);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_MEASURE = 3'd1,
    ST_MULT    = 3'd2,
    ST_DIV     = 3'd3,
    ST_DONE    = 3'd4
  } state_t;

  localparam logic [9:0]  MAX_C    = 10'(P_MAX_CYCLES);
  localparam logic [11:0] MUL_C    = 12'(P_MUL);
  localparam logic [4:0]  DIV_C    = 5'(P_DIV);
  localparam logic [3:0]  LAST_IT  = 4'd11;

  state_t      state;
  state_t      state_next;

  logic        pulse_meta;
  logic        pulse_sync;
  logic        pulse_prev;
  logic [1:0]  warm;
  logic        armed;
  logic        rise;
  logic        fall;

  logic [9:0]  count;
  logic [11:0] product;
  logic [11:0] quotient;
  logic [3:0]  remainder;
  logic [3:0]  iter;

  logic [3:0]  div_idx;
  logic [4:0]  trial;
  logic        div_ge;
  logic [4:0]  trial_rem;
  logic [11:0] quot_next;

  // Synchronizer and edge detector. The flops reset to 0, so a pulse that is
  // already high at reset release would look like a fresh rising edge. Rising
  // edges are only accepted once the synchronizer has filled (warm == 2) and
  // a low level has been seen, so such a pulse is skipped until it falls.
  always_ff @(posedge in_Clk or posedge in_Rst) begin
    if (in_Rst) begin
      pulse_meta <= 1'b0;
      pulse_sync <= 1'b0;
      pulse_prev <= 1'b0;
      warm       <= '0;
      armed      <= 1'b0;
    end else begin
      pulse_meta <= in_Pulse;
      pulse_sync <= pulse_meta;
      pulse_prev <= pulse_sync;
      if (warm != 2'd2) begin
        warm <= warm + 2'd1;
      end
      if (warm == 2'd2 && !pulse_sync) begin
        armed <= 1'b1;
      end
    end
  end

  assign rise = pulse_sync & ~pulse_prev & armed;
  assign fall = ~pulse_sync & pulse_prev;

  // Restoring division step: bring down the next product bit MSB first.
  always_comb begin
    div_idx   = LAST_IT - iter;
    trial     = {remainder, product[div_idx]};
    div_ge    = (trial >= DIV_C);
    trial_rem = div_ge ? (trial - DIV_C) : trial;
    quot_next = {quotient[10:0], div_ge};
  end

  always_ff @(posedge in_Clk or posedge in_Rst) begin
    if (in_Rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    out_Valid  = 1'b0;
    out_Busy   = (state != ST_IDLE);
    unique case (state)
      ST_IDLE: begin
        if (rise) begin
          state_next = ST_MEASURE;
        end
      end
      ST_MEASURE: begin
        if (fall) begin
          state_next = (count > MAX_C) ? ST_IDLE : ST_MULT;
        end
      end
      ST_MULT: begin
        state_next = ST_DIV;
      end
      ST_DIV: begin
        if (iter == LAST_IT) begin
          state_next = ST_DONE;
        end
      end
      ST_DONE: begin
        out_Valid  = 1'b1;
        state_next = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge in_Clk or posedge in_Rst) begin
    if (in_Rst) begin
      count       <= '0;
      product     <= '0;
      quotient    <= '0;
      remainder   <= '0;
      iter        <= '0;
      out_Degrees <= '0;
      out_Error   <= 1'b0;
    end else begin
      out_Error <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (rise) begin
            count <= '0;
          end
        end
        ST_MEASURE: begin
          if (fall) begin
            if (count > MAX_C) begin
              out_Error <= 1'b1;
            end
          end else if (pulse_sync && in_Tick && count != '1) begin
            count <= count + 10'd1;
          end
        end
        ST_MULT: begin
          product   <= {2'b00, count} * MUL_C;
          quotient  <= '0;
          remainder <= '0;
          iter      <= '0;
        end
        ST_DIV: begin
          quotient  <= quot_next;
          remainder <= trial_rem[3:0];
          iter      <= iter + 4'd1;
          // Loaded on the DIV->DONE edge so the new angle is visible in the
          // same cycle that out_Valid is decoded from ST_DONE.
          if (iter == LAST_IT) begin
            out_Degrees <= quot_next[8:0];
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pulse_to_degrees.sv
// Directed bench for pulse_to_degrees. Each pulse is held high, given an
// exact number of ticks well inside the high phase, then dropped; the
// following window is scanned for strobes, their latency and the angle.
module tb_pulse_to_degrees;

  logic       in_Clk;
  logic       in_Rst;
  logic       in_Pulse;
  logic       in_Tick;
  logic [8:0] out_Degrees;
  logic       out_Valid;
  logic       out_Error;
  logic       out_Busy;

  int n_cmp;
  int n_bad;

  pulse_to_degrees #(
    .P_MAX_CYCLES(200),
    .P_MUL(18),
    .P_DIV(10)
  ) dut (
    .in_Clk(in_Clk),
    .in_Rst(in_Rst),
    .in_Pulse(in_Pulse),
    .in_Tick(in_Tick),
    .out_Degrees(out_Degrees),
    .out_Valid(out_Valid),
    .out_Error(out_Error),
    .out_Busy(out_Busy)
  );

  initial in_Clk = 1'b0;
  always #5 in_Clk = ~in_Clk;

  task automatic check_eq(input string tag, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Raise the pulse, give n ticks on alternate cycles, leave it high a
  // little longer. Returns at a negedge with in_Pulse still high.
  task automatic run_pulse(input int n);
    @(negedge in_Clk);
    in_Pulse = 1'b1;
    repeat (4) @(negedge in_Clk);
    for (int i = 0; i < n; i++) begin
      in_Tick = 1'b1;
      @(negedge in_Clk);
      in_Tick = 1'b0;
      @(negedge in_Clk);
    end
    repeat (3) @(negedge in_Clk);
  endtask

  // Scan 40 negedges after the drop (made at negedge 0). The fall is seen
  // in the cycle observed at negedge 2 (F); error shows at F+1 = 3 and
  // the valid strobe at F+14 = 16.
  task automatic observe(input bit inject, output int vcnt, output int ecnt,
                         output int both, output int lat);
    vcnt = 0; ecnt = 0; both = 0; lat = -1;
    for (int k = 1; k <= 40; k++) begin
      @(negedge in_Clk);
      if (out_Valid) vcnt++;
      if (out_Error) ecnt++;
      if (out_Valid && out_Error) both++;
      if ((out_Valid || out_Error) && lat < 0) lat = k;
      if (inject && k == 6) in_Pulse = 1'b1;
      if (inject && k == 9) in_Pulse = 1'b0;
    end
  endtask

  task automatic check_case(input string tag, input int n, input bit inject,
                            input int exp_v, input int exp_e,
                            input int exp_lat, input int exp_deg);
    int vcnt, ecnt, both, lat;
    run_pulse(n);
    if (n >= 1023) check_eq({tag, ".sat_count"}, int'(dut.count), 1023);
    in_Pulse = 1'b0;
    observe(inject, vcnt, ecnt, both, lat);
    check_eq({tag, ".nvalid"},  vcnt, exp_v);
    check_eq({tag, ".nerror"},  ecnt, exp_e);
    check_eq({tag, ".both"},    both, 0);
    check_eq({tag, ".latency"}, lat, exp_lat);
    check_eq({tag, ".degrees"}, int'(out_Degrees), exp_deg);
    check_eq({tag, ".busy"},    int'(out_Busy), 0);
  endtask

  initial begin
    int vcnt, ecnt, both, lat, busy_cnt;
    n_cmp    = 0;
    n_bad    = 0;
    in_Rst   = 1'b1;
    in_Pulse = 1'b0;
    in_Tick  = 1'b0;
    repeat (3) @(negedge in_Clk);
    check_eq("rst.degrees", int'(out_Degrees), 0);
    check_eq("rst.valid",   int'(out_Valid), 0);
    check_eq("rst.error",   int'(out_Error), 0);
    check_eq("rst.busy",    int'(out_Busy), 0);
    in_Rst = 1'b0;
    repeat (5) @(negedge in_Clk);

    // count * 18 / 10, truncated
    check_case("p100",  100,  1'b0, 1, 0, 16, 180);
    check_case("p200",  200,  1'b0, 1, 0, 16, 360);
    check_case("p201",  201,  1'b0, 0, 1, 3,  360);
    check_case("p55",   55,   1'b0, 1, 0, 16, 99);
    check_case("p7",    7,    1'b0, 1, 0, 16, 12);
    check_case("p1",    1,    1'b0, 1, 0, 16, 1);
    check_case("p0",    0,    1'b0, 1, 0, 16, 0);
    check_case("p3",    3,    1'b0, 1, 0, 16, 5);
    check_case("p1100", 1100, 1'b0, 0, 1, 3,  5);
    check_case("p10_inj", 10, 1'b1, 1, 0, 16, 18);
    check_case("p20",   20,   1'b0, 1, 0, 16, 36);

    // Reset at F+6 (mid-DIV), pulse raised during reset and held through
    // release: nothing may be measured until it falls and rises again.
    run_pulse(30);
    in_Pulse = 1'b0;
    repeat (8) @(negedge in_Clk);
    in_Rst = 1'b1;
    #1;
    check_eq("rst_mid.degrees", int'(out_Degrees), 0);
    check_eq("rst_mid.valid",   int'(out_Valid), 0);
    check_eq("rst_mid.error",   int'(out_Error), 0);
    check_eq("rst_mid.busy",    int'(out_Busy), 0);
    in_Pulse = 1'b1;
    repeat (3) @(negedge in_Clk);
    in_Rst = 1'b0;
    busy_cnt = 0;
    vcnt = 0;
    ecnt = 0;
    for (int k = 0; k < 30; k++) begin
      @(negedge in_Clk);
      if (out_Busy)  busy_cnt++;
      if (out_Valid) vcnt++;
      if (out_Error) ecnt++;
    end
    in_Pulse = 1'b0;
    observe(1'b0, vcnt, ecnt, both, lat);
    check_eq("rst_hold.busy",   busy_cnt, 0);
    check_eq("rst_hold.nvalid", vcnt, 0);
    check_eq("rst_hold.nerror", ecnt, 0);
    check_eq("rst_hold.lat",    lat, -1);
    check_case("p50", 50, 1'b0, 1, 0, 16, 90);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/pulse_to_degrees.md
PULSE_TO_DEGREES -- requirements
Module: pulse_to_degrees

Interface
REQ-001 Parameter P_MAX_CYCLES, default 200: largest legal pulse width in ticks (maps to 360 degrees).
REQ-002 Parameter P_MUL, default 18: numerator of the cycles-to-degrees ratio.
REQ-003 Parameter P_DIV, default 10: denominator of the cycles-to-degrees ratio.
REQ-004 in_Clk  input  1  single system clock; all logic on its rising edge.
REQ-005 in_Rst  input  1  reset; asynchronous and active-high.
REQ-006 in_Pulse  input  1  asynchronous servo-style PWM pulse to be measured.
REQ-007 in_Tick  input  1  one-clock count-enable strobe; one tick equals one "cycle" unit.
REQ-008 out_Degrees  output  9  last valid measured angle, 0..360.
REQ-009 out_Valid  output  1  one-clock strobe; out_Degrees updated this cycle.
REQ-010 out_Error  output  1  one-clock strobe; measured pulse exceeded P_MAX_CYCLES.
REQ-011 out_Busy  output  1  high in every state except IDLE.

Function
REQ-012 in_Pulse SHALL pass through a 2-flop synchronizer; an edge detector SHALL compare the synchronized value with its previous registered value.
REQ-013 FSM states SHALL be IDLE, MEASURE, MULT, DIV, DONE; the state register SHALL be 3 bits.
REQ-014 IDLE: on a detected rising edge, clear the 10-bit width counter and go to MEASURE; otherwise stay.
REQ-015 MEASURE: while the synchronized pulse is high, increment the counter by 1 on each cycle with in_Tick=1; the counter SHALL saturate at 1023.
REQ-016 MEASURE: on a detected falling edge with count > P_MAX_CYCLES, assert out_Error for the next cycle only, leave out_Degrees unchanged, and return to IDLE.
REQ-017 MEASURE: on a detected falling edge with count <= P_MAX_CYCLES, go to MULT.
REQ-018 A tick coincident with the falling-edge detection cycle SHALL NOT be counted.
REQ-019 MULT: in one clock, form product = count * P_MUL as a 12-bit unsigned value (max 3600); then go to DIV.
REQ-020 DIV: restoring shift-subtract division of product by P_DIV, one quotient bit per clock, MSB first, exactly 12 iterations; the 4-bit remainder SHALL be discarded (quotient truncated).
REQ-021 DONE: load quotient[8:0] into out_Degrees, assert out_Valid for exactly this cycle, then return to IDLE.
REQ-022 Latency: falling edge detected at cycle F -> MULT at F+1, DIV at F+2..F+13, DONE (out_Valid=1) at F+14.
REQ-023 Edges on in_Pulse while in MULT, DIV or DONE SHALL be ignored; a pulse whose rising edge occurs outside IDLE SHALL NOT be measured.
REQ-024 out_Valid and out_Error SHALL never be high in the same cycle.
REQ-025 out_Degrees SHALL hold its value between out_Valid strobes and after error events.

Reset
REQ-026 While in_Rst=1, asynchronously: state=IDLE, counter=0, product/quotient/remainder=0, synchronizer and edge flops=0, out_Degrees=0, out_Valid=0, out_Error=0, out_Busy=0.
REQ-027 Reset asserted mid-MEASURE or mid-DIV SHALL abort the operation with no out_Valid or out_Error strobe.
REQ-028 After reset release, a pulse already high SHALL NOT be measured until it falls and a new rising edge is detected.

Verification
REQ-029 Pulse spanning 100 ticks -> out_Valid once, out_Degrees=180, at F+14.
REQ-030 Pulse spanning 200 ticks -> out_Degrees=360; 201 ticks -> out_Error one cycle, out_Degrees keeps 360, no out_Valid.
REQ-031 Pulse spanning 55 ticks -> 990/10 -> out_Degrees=99; 1 tick -> out_Degrees=1; 0 ticks -> out_Degrees=0 with out_Valid.
REQ-032 Pulse held 1100 ticks -> counter saturates at 1023, out_Error strobe, FSM back in IDLE.
REQ-033 Second rising edge injected during DIV -> ignored, exactly one out_Valid; next pulse starting in IDLE is measured normally.
REQ-034 in_Rst pulsed at F+6 -> all outputs 0 immediately, no strobe; in_Pulse high at release -> no measurement until the next rising edge.
